imm_encoder: RTL

//  Inverse of the immediate decoder. Takes a 32-bit immediate in the decoder's

---
 rtl/imm_enc_if.sv | 21 ++
 rtl/imm_encoder.sv | 94 +++++++++
 2 files changed

// File: rtl/imm_enc_if.sv
// imm_enc_if: request/result handshake bundle for imm_encoder.
interface imm_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_fmt;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic        out_rt_fail;
    modport master (
        output in_valid, in_imm, in_fmt, in_base, out_ready,
        input  in_ready, out_valid, out_instr, out_err, out_rt_fail
    );
    modport slave (
        input  in_valid, in_imm, in_fmt, in_base, out_ready,
        output in_ready, out_valid, out_instr, out_err, out_rt_fail
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a decoder-scaled immediate into an instruction word, 2-stage valid/ready pipe.
// Define IMM_ENC_RT_CHECK_EN to build the decode-back round-trip checker driving out_rt_fail.
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_enc_if.slave             bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_base;
    logic [19:0] s1_imm;
    logic [1:0]  s1_err;
    logic        s1_adv;
    logic        s2_adv;
    logic        hi12_ok;
    logic        hi20_ok;
    logic [1:0]  chk_err;
    logic [31:0] merged;
    logic        rt_fail;

    assign s2_adv      = !bus.out_valid | bus.out_ready;
    assign s1_adv      = !s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;
    assign hi12_ok     = &bus.in_imm[31:11] | ~|bus.in_imm[31:11];
    assign hi20_ok     = &bus.in_imm[31:19] | ~|bus.in_imm[31:19];
    assign chk_err     = bus.in_fmt > 3'd4 ? 2'b10 :
                         ((bus.in_fmt >= 3'd3 ? hi20_ok : hi12_ok) ? 2'b00 : 2'b01);

    always_comb begin
        merged = s1_base;
        case (s1_fmt)
            3'd0: merged = {s1_imm[11:0], s1_base[19:0]};
            3'd1: merged = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
            3'd2: merged = {s1_imm[11], s1_imm[9:4], s1_base[24:12], s1_imm[3:0], s1_imm[10], s1_base[6:0]};
            3'd3: merged = {s1_imm[19:0], s1_base[11:0]};
            3'd4: merged = {s1_imm[19], s1_imm[9:0], s1_imm[10], s1_imm[18:11], s1_base[11:0]};
            default: merged = s1_base;
        endcase
    end

`ifdef IMM_ENC_RT_CHECK_EN
    logic [31:0] rt_dec;
    logic [31:0] rt_ref;
    always_comb begin
        rt_dec = 32'd0;
        case (s1_fmt)
            3'd0: rt_dec = {{20{merged[31]}}, merged[31:20]};
            3'd1: rt_dec = {{20{merged[31]}}, merged[31:25], merged[11:7]};
            3'd2: rt_dec = {{20{merged[31]}}, merged[31], merged[7], merged[30:25], merged[11:8]};
            3'd3: rt_dec = {{12{merged[31]}}, merged[31:12]};
            3'd4: rt_dec = {{12{merged[31]}}, merged[31], merged[19:12], merged[20], merged[30:21]};
            default: rt_dec = 32'd0;
        endcase
        rt_ref  = s1_fmt >= 3'd3 ? {{12{s1_imm[19]}}, s1_imm} : {{20{s1_imm[11]}}, s1_imm[11:0]};
        rt_fail = s1_err != 2'b10 && rt_dec != rt_ref;
    end
`else
    assign rt_fail = 1'b0;
`endif

    // Payload registers carry no reset; s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (s1_adv && bus.in_valid) begin
            s1_fmt  <= bus.in_fmt;
            s1_base <= bus.in_base;
            s1_imm  <= bus.in_imm[19:0];
            s1_err  <= chk_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_instr   <= 32'd0;
            bus.out_err     <= 2'b00;
            bus.out_rt_fail <= 1'b0;
            err_cnt         <= '0;
        end else begin
            if (s1_adv) s1_valid <= bus.in_valid;
            if (s2_adv) bus.out_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                bus.out_instr   <= merged;
                bus.out_err     <= s1_err;
                bus.out_rt_fail <= rt_fail;
            end
            if (bus.out_valid && bus.out_ready && |bus.out_err && !(&err_cnt))
                err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule
